// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam int PKG_XLEN = 32;

    // addi x0,x0,0 presented to ID whenever nothing is buffered
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Sequential fetch stride in bytes
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [PKG_XLEN-1:0] pc;
        logic [PKG_XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// Circular prefetch queue of {pc, inst} entries with push, pop, flush and occupancy count.
module if_fetch_fifo
    import if_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = 4,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  entry_t        wr_data,
    output entry_t        rd_data,
    output logic [AW:0]   count,
    output logic          empty
);

    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            full;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !flush && !full;
    assign do_pop  = pop && !flush && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue like reset does
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage: issues sequential PCs to a 1-cycle imem and buffers the
// returned {pc, inst} pairs in a prefetch queue drained by ID via valid/ready.
// Optional macro IF_PERF_CNT_EN adds perf_fetch/perf_flush/perf_stall counters.
module if_prefetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(if_pkg::NOP_INST)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            branch_sel,
    input  logic [XLEN-1:0] branch_inp,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] pc_present,
    output logic [XLEN-1:0] inst
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch,
    output logic [31:0]     perf_flush,
    output logic [31:0]     perf_stall
`endif
);

    import if_pkg::*;

    localparam int CW = $clog2(QDEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    logic [XLEN-1:0] fpc;
    logic            inflight;
    logic [XLEN-1:0] inflight_pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   occupancy;
    logic            issue;
    logic            push;
    logic            pop;
    logic            empty;
    entry_t          head;
    entry_t          resp;

    // A request is only issued when a queue slot is guaranteed for its response,
    // so the queue can never overflow.
    assign occupancy = count + CW'(inflight);
    assign issue     = !reset && !branch_sel && (occupancy < CW'(QDEPTH));

    // A redirect kills the response arriving this cycle and blocks ID from popping.
    assign push      = inflight && !branch_sel;
    assign pop       = !empty && id_ready && !branch_sel;
    assign resp      = '{pc: inflight_pc, inst: imem_rdata};

    if_fetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (QDEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .flush   (branch_sel),
        .wr_data (resp),
        .rd_data (head),
        .count   (count),
        .empty   (empty)
    );

    // Fetch PC and single outstanding request tracking; clearing inflight on a redirect is the kill
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc         <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (branch_sel) begin
            fpc         <= branch_inp & ~XLEN'(3);
            inflight    <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fpc;
                fpc         <= fpc + XLEN'(PC_STEP);
            end
        end
    end

    // Drive imem and present the queue head, substituting a NOP when empty
    always_comb begin
        imem_req   = issue;
        imem_addr  = fpc;
        if_valid   = !empty;
        pc_present = '0;
        inst       = NOP_INST;
        if (!empty) begin
            pc_present = head.pc;
            inst       = head.inst;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Free-running event counters for entries pushed, redirects and ID back-pressure
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch <= '0;
            perf_flush <= '0;
            perf_stall <= '0;
        end else begin
            if (push) begin
                perf_fetch <= perf_fetch + 32'd1;
            end
            if (branch_sel) begin
                perf_flush <= perf_flush + 32'd1;
            end
            if (!empty && !id_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Self-checking bench for if_prefetch_unit: directed scenarios followed by random
// redirect/back-pressure/reset traffic, all compared against a queue-based model.
// Build with IF_PERF_CNT_EN defined to also check the performance counters.
module tb_if_prefetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        branch_sel = 1'b0;
    logic [31:0] branch_inp = '0;
    logic        id_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_valid;
    logic [31:0] pc_present;
    logic [31:0] inst;

    logic        reset2 = 1'b1;
    logic        branch_sel2 = 1'b0;
    logic [31:0] branch_inp2 = '0;
    logic        id_ready2 = 1'b1;
    logic [31:0] imem_rdata2 = '0;
    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic        if_valid2;
    logic [31:0] pc_present2;
    logic [31:0] inst2;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch, perf_flush, perf_stall;
    logic [31:0] perf_fetch2, perf_flush2, perf_stall2;
`endif

    if_prefetch_unit dut (
        .clk(clk), .reset(reset), .branch_sel(branch_sel), .branch_inp(branch_inp),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .id_ready(id_ready), .pc_present(pc_present), .inst(inst)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch(perf_fetch), .perf_flush(perf_flush), .perf_stall(perf_stall)
`endif
    );

    if_prefetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .reset(reset2), .branch_sel(branch_sel2), .branch_inp(branch_inp2),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .if_valid(if_valid2), .id_ready(id_ready2), .pc_present(pc_present2), .inst(inst2)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch(perf_fetch2), .perf_flush(perf_flush2), .perf_stall(perf_stall2)
`endif
    );

    // Reference model state: the queue as a list of {pc, inst}, one pending request
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    bit          mPend = 1'b0;
    logic [31:0] mPendPc = '0;
    logic [31:0] mFpc = '0;
    bit          modelKnown = 1'b0;
    int          mFetch = 0;
    int          mFlush = 0;
    int          mStall = 0;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Contents of the fake instruction memory
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every DUT output against the model for the inputs currently applied
    task automatic checkOutput();
        bit expReq;
        if (!modelKnown) return;
        expReq = !reset && !branch_sel && ((mq.size() + int'(mPend)) < 4);
        check("imem_req", {31'd0, imem_req}, {31'd0, expReq});
        check("imem_addr", imem_addr, mFpc);
        check("if_valid", {31'd0, if_valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
        check("pc_present", pc_present, (mq.size() > 0) ? mq[0].pc : 32'h0);
        check("inst", inst, (mq.size() > 0) ? mq[0].inst : 32'h0000_0013);
`ifdef IF_PERF_CNT_EN
        check("perf_fetch", perf_fetch, mFetch);
        check("perf_flush", perf_flush, mFlush);
        check("perf_stall", perf_stall, mStall);
`endif
    endtask

    task automatic applyStimulus(input bit r, input bit b, input logic [31:0] t, input bit y);
        @(negedge clk);
        reset      = r;
        branch_sel = b;
        branch_inp = t;
        id_ready   = y;
        #1;
        checkOutput();
    endtask

    // Advance one clock: update the model from the rules and serve imem responses
    task automatic clockEdge();
        bit          sReq, sReq2, req;
        logic [31:0] sAddr, sAddr2;
        sReq   = imem_req;
        sAddr  = imem_addr;
        sReq2  = imem_req2;
        sAddr2 = imem_addr2;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            mPend      = 1'b0;
            mFpc       = 32'h0;
            mFetch     = 0;
            mFlush     = 0;
            mStall     = 0;
            modelKnown = 1'b1;
        end else begin
            req = !branch_sel && ((mq.size() + int'(mPend)) < 4);
            if (mq.size() > 0 && !id_ready) mStall++;
            if (branch_sel) begin
                mq.delete();
                mPend = 1'b0;
                mFpc  = branch_inp & ~32'h3;
                mFlush++;
            end else begin
                if (mq.size() > 0 && id_ready) void'(mq.pop_front());
                if (mPend) begin
                    mq.push_back('{pc: mPendPc, inst: memWord(mPendPc)});
                    mFetch++;
                end
                mPend = req;
                if (req) begin
                    mPendPc = mFpc;
                    mFpc    = mFpc + 32'd4;
                end
            end
        end
        #1;
        imem_rdata  = sReq  ? memWord(sAddr)  : $urandom;
        imem_rdata2 = sReq2 ? memWord(sAddr2) : $urandom;
    endtask

    initial begin
        bit          found;
        int          idx;
        logic [31:0] wrapPcs [4];
        bit          r, b, y;
        logic [31:0] t;

        // Reset state and first fetches after release
        applyStimulus(1, 0, 0, 1); clockEdge();
        applyStimulus(1, 0, 0, 1);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_inst", inst, 32'h0000_0013);
        check("rst_pc", pc_present, 32'h0);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        clockEdge();
        applyStimulus(0, 0, 0, 1);
        check("t1_req0", imem_addr, 32'h0);
        clockEdge();
        applyStimulus(0, 0, 0, 1);
        check("t1_req4", imem_addr, 32'h4);
        clockEdge();
        applyStimulus(0, 0, 0, 1);
        check("t1_req8", imem_addr, 32'h8);
        check("t1_first_pc", pc_present, 32'h0);
        check("t1_first_valid", {31'd0, if_valid}, 32'd1);
        clockEdge();

        // ID stalled: queue fills to four entries and fetch halts at 0x10
        applyStimulus(1, 0, 0, 0); clockEdge();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, 0); clockEdge();
        end
        applyStimulus(0, 0, 0, 0);
        check("t2_req_low", {31'd0, imem_req}, 32'd0);
        check("t2_fpc", imem_addr, 32'h10);
        clockEdge();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 1);
            check("t2_drain_pc", pc_present, 32'(4 * i));
            clockEdge();
        end

        // Redirect to 40 when 32 is at the head
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            applyStimulus(0, 0, 0, 1);
            if (if_valid && pc_present == 32'd32) begin
                found      = 1'b1;
                branch_sel = 1'b1;
                branch_inp = 32'd40;
                #1;
                checkOutput();
            end
            clockEdge();
        end
        check("t3_found32", {31'd0, found}, 32'd1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(0, 0, 0, 1);
            if (if_valid) begin
                found = 1'b1;
                check("t3_target_pc", pc_present, 32'd40);
            end
            clockEdge();
        end
        check("t3_valid_seen", {31'd0, found}, 32'd1);

        // Misaligned target, then redirect again while the 0x28 fetch is in flight
        applyStimulus(0, 1, 32'h2B, 1); clockEdge();
        applyStimulus(0, 0, 0, 1);
        check("t4_req", {31'd0, imem_req}, 32'd1);
        check("t4_addr", imem_addr, 32'h28);
        clockEdge();
        applyStimulus(0, 1, 32'h100, 1); clockEdge();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(0, 0, 0, 1);
            if (if_valid) begin
                found = 1'b1;
                check("t4_pc", pc_present, 32'h100);
                check("t4_inst", inst, memWord(32'h100));
            end
            clockEdge();
        end
        check("t4_valid_seen", {31'd0, found}, 32'd1);

        // Reset with the queue full
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 0); clockEdge();
        end
        applyStimulus(0, 0, 0, 0);
        check("t6_full_valid", {31'd0, if_valid}, 32'd1);
        clockEdge();
        applyStimulus(1, 0, 0, 0); clockEdge();
        applyStimulus(1, 0, 0, 0);
        check("t6_valid", {31'd0, if_valid}, 32'd0);
        check("t6_inst", inst, 32'h0000_0013);
`ifdef IF_PERF_CNT_EN
        check("t6_perf_fetch", perf_fetch, 32'd0);
        check("t6_perf_flush", perf_flush, 32'd0);
        check("t6_perf_stall", perf_stall, 32'd0);
`endif
        clockEdge();

        // Random traffic: redirects (some misaligned, some near wrap), stalls, resets
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 99) == 0);
            b = ($urandom_range(0, 11) == 0);
            y = ($urandom_range(0, 3) != 0);
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : 32'($urandom_range(0, 4095));
            applyStimulus(r, b, t, y);
            clockEdge();
        end

        // PC wrap on the second instance reset to 0xFFFF_FFF8
        wrapPcs[0] = 32'hFFFF_FFF8;
        wrapPcs[1] = 32'hFFFF_FFFC;
        wrapPcs[2] = 32'h0;
        wrapPcs[3] = 32'h4;
        reset2 = 1'b1;
        applyStimulus(0, 0, 0, 1); clockEdge();
        reset2 = 1'b0;
        idx = 0;
        for (int i = 0; i < 20 && idx < 4; i++) begin
            applyStimulus(0, 0, 0, 1);
            if (if_valid2) begin
                check("t5_wrap_pc", pc_present2, wrapPcs[idx]);
                check("t5_wrap_inst", inst2, memWord(wrapPcs[idx]));
                idx++;
            end
            clockEdge();
        end
        check("t5_wrap_count", 32'(idx), 32'd4);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
